// File: rtl/kmp_search_ctrl.sv
// Knuth-Morris-Pratt search sequencer: loads the pattern, builds its failure table,
// then scans the text ROM once, counting overlapping matches without rewinding.
module kmp_search_ctrl #(
  parameter int PAT_W    = 3,
  parameter int TEXT_W   = 14,
  parameter int TEXT_LEN = 11064,
  parameter int DATA_W   = 8,
  parameter int COUNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inicio,
  input  logic [PAT_W:0]     pat_len,
  output logic [PAT_W-1:0]   pat_addr,
  input  logic [DATA_W-1:0]  pat_data,
  output logic [TEXT_W-1:0]  text_addr,
  input  logic [DATA_W-1:0]  text_data,
  output logic [COUNT_W-1:0] instancias,
  output logic               busy,
  output logic               done,
  output logic [3:0]         actual_state
);
  localparam int PMAX = 1 << PAT_W;
  localparam logic [PAT_W:0]    PMAX_L = (PAT_W+1)'(PMAX);
  localparam logic [TEXT_W-1:0] T_LAST = TEXT_W'(TEXT_LEN - 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0, LOAD = 4'd1, FAIL = 4'd2, SCAN_WAIT = 4'd3, SCAN_CMP = 4'd4, DONE = 4'd5
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W:0]     len_q, len_d, i_q, i_d, k_q, k_d, q_q, q_d, l_clamp;
  logic [PAT_W-1:0]   pat_addr_q, pat_addr_d;
  logic [TEXT_W-1:0]  t_q, t_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d, adv;
  logic [DATA_W-1:0]  pat_q  [PMAX];
  logic [DATA_W-1:0]  pat_d  [PMAX];
  logic [PAT_W:0]     fail_q [PMAX];
  logic [PAT_W:0]     fail_d [PMAX];

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    i_d        = i_q;
    k_d        = k_q;
    q_d        = q_q;
    pat_addr_d = pat_addr_q;
    t_d        = t_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    fail_d     = fail_q;
    adv        = 1'b0;
    l_clamp    = (pat_len > PMAX_L) ? PMAX_L : pat_len;
    case (state_q)
      IDLE, DONE: begin
        if (inicio) begin
          len_d      = l_clamp;
          cnt_d      = '0;
          pat_addr_d = '0;
          t_d        = '0;
          i_d        = '0;
          state_d    = (l_clamp == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        // i_q counts LOAD cycles; ROM data trails the address by one cycle
        if (i_q != '0) pat_d[PAT_W'(i_q - 1'b1)] = pat_data;
        if (i_q == len_q) begin
          state_d   = FAIL;
          i_d       = (PAT_W+1)'(1);
          k_d       = '0;
          fail_d[0] = '0;
        end else begin
          i_d = i_q + 1'b1;
          if (i_q + 1'b1 < len_q) pat_addr_d = PAT_W'(i_q + 1'b1);
        end
      end
      FAIL: begin
        if (i_q == len_q) begin
          state_d = SCAN_WAIT;
          q_d     = '0;
        end else if (pat_q[PAT_W'(i_q)] == pat_q[PAT_W'(k_q)]) begin
          fail_d[PAT_W'(i_q)] = k_q + 1'b1;
          k_d = k_q + 1'b1;
          i_d = i_q + 1'b1;
        end else if (k_q != '0) begin
          k_d = fail_q[PAT_W'(k_q - 1'b1)];
        end else begin
          fail_d[PAT_W'(i_q)] = '0;
          i_d = i_q + 1'b1;
        end
      end
      SCAN_WAIT: state_d = SCAN_CMP;
      SCAN_CMP: begin
        if (text_data == pat_q[PAT_W'(q_q)]) begin
          adv = 1'b1;
          if (q_q + 1'b1 == len_q) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            q_d = fail_q[PAT_W'(len_q - 1'b1)];
          end else begin
            q_d = q_q + 1'b1;
          end
        end else if (q_q != '0) begin
          // fall back through the table; text_data stays valid since text_addr holds
          q_d = fail_q[PAT_W'(q_q - 1'b1)];
        end else begin
          adv = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      if (t_q == T_LAST) begin
        state_d = DONE;
      end else begin
        t_d     = t_q + 1'b1;
        state_d = SCAN_WAIT;
      end
    end
    busy_d = (state_d == LOAD) || (state_d == FAIL) ||
             (state_d == SCAN_WAIT) || (state_d == SCAN_CMP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      i_q        <= '0;
      k_q        <= '0;
      q_q        <= '0;
      pat_addr_q <= '0;
      t_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int n = 0; n < PMAX; n++) begin
        pat_q[n]  <= '0;
        fail_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      i_q        <= i_d;
      k_q        <= k_d;
      q_q        <= q_d;
      pat_addr_q <= pat_addr_d;
      t_q        <= t_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pat_q      <= pat_d;
      fail_q     <= fail_d;
    end
  end

  assign pat_addr     = pat_addr_q;
  assign text_addr    = t_q;
  assign instancias   = cnt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign actual_state = state_q;
endmodule

// File: tb/tb_kmp_search_ctrl.sv
// Bench for kmp_search_ctrl: a full-size instance over an 11064-char text and a small
// instance (6-char text, 2-bit counter), both checked against a brute-force match count.
`timescale 1ns/1ps
module tb_kmp_search_ctrl;
  localparam int BLEN = 11064;
  localparam int SLEN = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        b_rst, b_inicio, b_busy, b_done;
  logic [3:0]  b_pat_len, b_state;
  logic [2:0]  b_pat_addr;
  logic [7:0]  b_pat_data, b_text_data, b_inst;
  logic [13:0] b_text_addr;

  logic        s_rst, s_inicio, s_busy, s_done;
  logic [3:0]  s_pat_len, s_state;
  logic [2:0]  s_pat_addr, s_text_addr;
  logic [7:0]  s_pat_data, s_text_data;
  logic [1:0]  s_inst;

  logic [7:0] b_pat  [0:7];
  logic [7:0] b_text [0:BLEN-1];
  logic [7:0] s_pat  [0:7];
  logic [7:0] s_text [0:7];

  int n_checks = 0;
  int n_errors = 0;

  kmp_search_ctrl dut (
    .clk(clk), .rst(b_rst), .inicio(b_inicio), .pat_len(b_pat_len),
    .pat_addr(b_pat_addr), .pat_data(b_pat_data), .text_addr(b_text_addr),
    .text_data(b_text_data), .instancias(b_inst), .busy(b_busy), .done(b_done),
    .actual_state(b_state)
  );

  kmp_search_ctrl #(.PAT_W(3), .TEXT_W(3), .TEXT_LEN(SLEN), .DATA_W(8), .COUNT_W(2)) dut_s (
    .clk(clk), .rst(s_rst), .inicio(s_inicio), .pat_len(s_pat_len),
    .pat_addr(s_pat_addr), .pat_data(s_pat_data), .text_addr(s_text_addr),
    .text_data(s_text_data), .instancias(s_inst), .busy(s_busy), .done(s_done),
    .actual_state(s_state)
  );

  // synchronous ROM models: data one cycle after the address
  always @(posedge clk) begin
    b_pat_data  <= b_pat[b_pat_addr];
    b_text_data <= (int'(b_text_addr) < BLEN) ? b_text[b_text_addr] : 8'h00;
    s_pat_data  <= s_pat[s_pat_addr];
    s_text_data <= s_text[s_text_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] txt_at(input bit big, input int a);
    return big ? b_text[a] : s_text[a];
  endfunction

  function automatic logic [7:0] pat_at(input bit big, input int a);
    return big ? b_pat[a] : s_pat[a];
  endfunction

  // count every (overlapping) alignment where the pattern appears, then saturate
  function automatic int ref_count(input bit big, input int len);
    int n, cap, c, l;
    bit hit;
    l = (len > 8) ? 8 : len;
    n = big ? BLEN : SLEN;
    cap = big ? 255 : 3;
    c = 0;
    if (l == 0) return 0;
    for (int p = 0; p + l <= n; p++) begin
      hit = 1'b1;
      for (int j = 0; j < l; j++)
        if (txt_at(big, p + j) != pat_at(big, j)) hit = 1'b0;
      if (hit) c++;
    end
    return (c > cap) ? cap : c;
  endfunction

  // longest proper prefix of s_pat[0..i] that is also its suffix
  function automatic int ref_border(input int i);
    bit ok;
    for (int m = i; m > 0; m--) begin
      ok = 1'b1;
      for (int j = 0; j < m; j++)
        if (s_pat[j] != s_pat[i - m + 1 + j]) ok = 1'b0;
      if (ok) return m;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_s(input int len);
    s_pat_len = len[3:0];
    s_inicio  = 1'b1;
    tick();
    s_inicio  = 1'b0;
  endtask

  task automatic start_b(input int len);
    b_pat_len = len[3:0];
    b_inicio  = 1'b1;
    tick();
    b_inicio  = 1'b0;
  endtask

  task automatic wait_done_s(input bit poke, output int load_cyc, output int decreases,
                             output bit timeout);
    int prev;
    bit poked;
    load_cyc = 0; decreases = 0; timeout = 1'b1; prev = 0; poked = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (s_done) begin
        timeout = 1'b0;
        break;
      end
      if (s_state == 4'd1) load_cyc++;
      if (int'(s_text_addr) < prev) decreases++;
      prev = int'(s_text_addr);
      if (poke && !poked && s_state == 4'd4) begin
        s_inicio  = 1'b1;
        s_pat_len = 4'd1;
        poked     = 1'b1;
      end else begin
        s_inicio = 1'b0;
      end
      tick();
    end
    s_inicio = 1'b0;
  endtask

  task automatic wait_done_b(output bit timeout);
    timeout = 1'b1;
    for (int c = 0; c < 40000; c++) begin
      if (b_done) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic run_s(input string tag, input int len, input bit poke, output int load_cyc,
                       output int decreases);
    bit to;
    start_s(len);
    wait_done_s(poke, load_cyc, decreases, to);
    check_eq({tag, "_timeout"}, {31'b0, to}, 32'd0);
    check_eq({tag, "_count"}, {30'b0, s_inst}, ref_count(1'b0, len));
  endtask

  task automatic set_s(input string p, input string t);
    for (int j = 0; j < 8; j++) s_pat[j] = (j < p.len()) ? p[j] : 8'h00;
    for (int j = 0; j < 8; j++) s_text[j] = (j < t.len()) ? t[j] : 8'h00;
  endtask

  initial begin
    int lc, dec, len;
    bit to;
    b_rst = 1'b1; s_rst = 1'b1; b_inicio = 1'b0; s_inicio = 1'b0;
    b_pat_len = '0; s_pat_len = '0;
    for (int j = 0; j < 8; j++) begin b_pat[j] = 8'h00; s_pat[j] = 8'h00; s_text[j] = 8'h00; end
    for (int j = 0; j < BLEN; j++) b_text[j] = 8'($urandom_range(65, 68));
    repeat (3) tick();
    check_eq("rst_s_state", {28'b0, s_state}, 32'd0);
    check_eq("rst_s_busy", {31'b0, s_busy}, 32'd0);
    check_eq("rst_s_done", {31'b0, s_done}, 32'd0);
    check_eq("rst_s_inst", {30'b0, s_inst}, 32'd0);
    check_eq("rst_s_paddr", {29'b0, s_pat_addr}, 32'd0);
    check_eq("rst_b_state", {28'b0, b_state}, 32'd0);
    check_eq("rst_b_taddr", {18'b0, b_text_addr}, 32'd0);
    b_rst = 1'b0; s_rst = 1'b0;
    tick();

    // overlap and failure table
    set_s("ABAB", "ABABAB");
    start_s(4);
    check_eq("abab_load_state", {28'b0, s_state}, 32'd1);
    wait_done_s(1'b0, lc, dec, to);
    check_eq("abab_timeout", {31'b0, to}, 32'd0);
    check_eq("abab_count", {30'b0, s_inst}, ref_count(1'b0, 4));
    check_eq("abab_busy", {31'b0, s_busy}, 32'd0);
    for (int n = 0; n < 4; n++)
      check_eq($sformatf("abab_fail%0d", n), {28'b0, dut_s.fail_q[n]}, ref_border(n));

    // fallback without rewinding
    set_s("AAB", "AAABCC");
    run_s("aab", 3, 1'b0, lc, dec);
    check_eq("aab_addr_monotonic", dec, 32'd0);

    // saturation and hold in DONE
    set_s("A", "AAAAAA");
    run_s("sat", 1, 1'b0, lc, dec);
    repeat (3) tick();
    check_eq("sat_hold", {30'b0, s_inst}, 32'd3);
    check_eq("sat_done", {31'b0, s_done}, 32'd1);

    // zero length goes straight to DONE with a cleared count
    start_s(0);
    check_eq("len0_state", {28'b0, s_state}, 32'd5);
    check_eq("len0_done", {31'b0, s_done}, 32'd1);
    check_eq("len0_inst", {30'b0, s_inst}, 32'd0);

    // length clamps to 8: LOAD spans L+1 cycles
    set_s("ABABABAB", "ABABAB");
    run_s("clamp", 9, 1'b0, lc, dec);
    check_eq("clamp_load_cycles", lc, 32'd9);

    // inicio while busy is ignored
    set_s("AB", "ABAABA");
    run_s("busy_start", 2, 1'b1, lc, dec);

    // randomized small searches
    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(1, 4);
      for (int j = 0; j < 8; j++) s_pat[j] = (j < len) ? 8'($urandom_range(65, 66)) : 8'h00;
      for (int j = 0; j < SLEN; j++) s_text[j] = 8'($urandom_range(65, 66));
      run_s($sformatf("rand%0d", r), len, 1'b0, lc, dec);
      check_eq($sformatf("rand%0d_monotonic", r), dec, 32'd0);
    end

    // full text: reset while scanning, then a clean search
    for (int j = 0; j < 3; j++) b_pat[j] = b_text[5 + j];
    start_b(3);
    to = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (b_state == 4'd3 && b_inst != 8'd0) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    check_eq("mid_reach_scan", {31'b0, to}, 32'd0);
    b_rst = 1'b1;
    tick();
    check_eq("mid_rst_state", {28'b0, b_state}, 32'd0);
    check_eq("mid_rst_inst", {24'b0, b_inst}, 32'd0);
    check_eq("mid_rst_taddr", {18'b0, b_text_addr}, 32'd0);
    check_eq("mid_rst_busy", {31'b0, b_busy}, 32'd0);
    b_rst = 1'b0;
    tick();
    start_b(3);
    wait_done_b(to);
    check_eq("full1_timeout", {31'b0, to}, 32'd0);
    check_eq("full1_count", {24'b0, b_inst}, ref_count(1'b1, 3));
    check_eq("full1_last_addr", {18'b0, b_text_addr}, BLEN - 1);

    // restart from DONE with a different pattern
    for (int j = 0; j < 4; j++) b_pat[j] = b_text[100 + j];
    start_b(4);
    check_eq("full2_cleared", {24'b0, b_inst}, 32'd0);
    wait_done_b(to);
    check_eq("full2_timeout", {31'b0, to}, 32'd0);
    check_eq("full2_count", {24'b0, b_inst}, ref_count(1'b1, 4));
    check_eq("full2_done", {31'b0, b_done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
